// File: rtl/memory_stage.sv
// Y86-64 SEQ memory stage: byte-serial little-endian access to a local data memory,
// sequenced by a start/done handshake, producing valM and the instruction status.
module memory_stage #(
  parameter int DMEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  icode,
  input  logic [63:0] valE,
  input  logic [63:0] valA,
  input  logic [63:0] valP,
  input  logic        instr_valid,
  input  logic        imem_error,
  output logic        busy,
  output logic        done,
  output logic [63:0] valM,
  output logic [2:0]  stat
);

  localparam int AW = $clog2(DMEM_BYTES);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  logic [7:0]    mem [DMEM_BYTES];

  logic [1:0]    state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [63:0]   data_q, data_d;
  logic [55:0]   rdBuf_q, rdBuf_d;
  logic [63:0]   valM_q, valM_d;
  logic [2:0]    stat_q, stat_d;

  logic          isRead, isWrite, isMem;
  logic [63:0]   reqAddr, reqData;
  logic [2:0]    reqStat;
  logic [AW-1:0] memIdx;
  logic [7:0]    memRd, wrByte;

  always_comb begin
    isRead  = (icode == 4'h5) || (icode == 4'h9) || (icode == 4'hB);
    isWrite = (icode == 4'h4) || (icode == 4'h8) || (icode == 4'hA);
    isMem   = isRead || isWrite;
    reqAddr = ((icode == 4'h9) || (icode == 4'hB)) ? valA : valE;
    reqData = (icode == 4'h8) ? valP : valA;
    if (imem_error)                                    reqStat = STAT_ADR;
    else if (!instr_valid)                             reqStat = STAT_INS;
    else if (icode == 4'h0)                            reqStat = STAT_HLT;
    else if (isMem && (reqAddr > 64'(DMEM_BYTES - 8))) reqStat = STAT_ADR;
    else                                               reqStat = STAT_AOK;
  end

  // Range check passed before entering RD/WR, so addr+cnt stays inside the array.
  assign memIdx = addr_q + AW'(cnt_q);
  assign memRd  = mem[memIdx];
  assign wrByte = data_q[{cnt_q, 3'b000} +: 8];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    rdBuf_d = rdBuf_q;
    valM_d  = valM_q;
    stat_d  = stat_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d = reqAddr[AW-1:0];
          data_d = reqData;
          cnt_d  = 3'd0;
          if ((reqStat != STAT_AOK) || !isMem) begin
            stat_d  = reqStat;
            state_d = S_DONE;
          end else begin
            state_d = isRead ? S_RD : S_WR;
          end
        end
      end
      S_RD: begin
        // Bytes 0..6 shift in from the top; byte 7 completes valM in one step.
        rdBuf_d = {memRd, rdBuf_q[55:8]};
        cnt_d   = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          valM_d  = {memRd, rdBuf_q};
          stat_d  = STAT_AOK;
          state_d = S_DONE;
        end
      end
      S_WR: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          stat_d  = STAT_AOK;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      addr_q  <= '0;
      data_q  <= '0;
      rdBuf_q <= '0;
      valM_q  <= '0;
      stat_q  <= STAT_AOK;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rdBuf_q <= rdBuf_d;
      valM_q  <= valM_d;
      stat_q  <= stat_d;
    end
  end

  // Memory contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (state_q == S_WR) mem[memIdx] <= wrByte;
  end

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);
  assign valM = valM_q;
  assign stat = stat_q;

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: table-driven instruction vectors plus
// hand-written sequences for start-while-busy and reset during a write.
module tb_memory_stage;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [3:0]  icode;
  logic [63:0] valE;
  logic [63:0] valA;
  logic [63:0] valP;
  logic        instr_valid;
  logic        imem_error;
  logic        busy;
  logic        done;
  logic [63:0] valM;
  logic [2:0]  stat;

  int checks = 0;
  int errors = 0;

  memory_stage #(.DMEM_BYTES(1024)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .icode       (icode),
    .valE        (valE),
    .valA        (valA),
    .valP        (valP),
    .instr_valid (instr_valid),
    .imem_error  (imem_error),
    .busy        (busy),
    .done        (done),
    .valM        (valM),
    .stat        (stat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  icode;
    logic [63:0] valE;
    logic [63:0] valA;
    logic [63:0] valP;
    logic        instrValid;
    logic        imemError;
    logic [2:0]  expStat;
    logic [63:0] expValM;
    int          expCycle;
  } vec_t;

  localparam int NVEC = 13;
  vec_t vecs [NVEC];

  // Results of the most recent operation window.
  int          doneCycle;
  int          doneCount;
  logic [2:0]  statAtDone;
  logic [63:0] valMAtDone;
  logic        busyCycle1;
  logic        busyAfter;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Starts one instruction in cycle 0 and observes 14 cycles at the falling edge.
  // extraStartCycle > 0 pulses start again for one cycle at that cycle number.
  task automatic applyStimulus(input logic [3:0] ic, input logic [63:0] e, input logic [63:0] a,
                               input logic [63:0] p, input logic iv, input logic ie,
                               input int extraStartCycle);
    @(posedge clk);
    #1;
    icode = ic; valE = e; valA = a; valP = p;
    instr_valid = iv; imem_error = ie;
    start = 1'b1;
    doneCycle = -1;
    doneCount = 0;
    statAtDone = 3'd0;
    valMAtDone = '0;
    busyCycle1 = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk);
      #1;
      start = (extraStartCycle > 0) && (k == extraStartCycle);
      @(negedge clk);
      if (k == 1) busyCycle1 = busy;
      if (done) begin
        doneCount++;
        if (doneCycle < 0) begin
          doneCycle  = k;
          statAtDone = stat;
          valMAtDone = valM;
        end
      end
    end
    busyAfter = busy;
  endtask

  task automatic runVector(input int i);
    string tag;
    tag = $sformatf("v%0d", i);
    applyStimulus(vecs[i].icode, vecs[i].valE, vecs[i].valA, vecs[i].valP,
                  vecs[i].instrValid, vecs[i].imemError, 0);
    checkOutput({tag, "_doneCycle"}, 64'(doneCycle), 64'(vecs[i].expCycle));
    checkOutput({tag, "_doneCount"}, 64'(doneCount), 64'd1);
    checkOutput({tag, "_stat"}, 64'(statAtDone), 64'(vecs[i].expStat));
    checkOutput({tag, "_valM"}, valMAtDone, vecs[i].expValM);
    checkOutput({tag, "_busyCycle1"}, 64'(busyCycle1), 64'd1);
    checkOutput({tag, "_busyAfter"}, 64'(busyAfter), 64'd0);
  endtask

  initial begin
    // icode valE valA valP instrValid imemError expStat expValM expCycle
    vecs[0]  = '{4'h4, 64'h13, 64'h1122334455667788, 64'h0, 1'b1, 1'b0, 3'd1, 64'h0, 9};
    vecs[1]  = '{4'h5, 64'h13, 64'h0, 64'h0, 1'b1, 1'b0, 3'd1, 64'h1122334455667788, 9};
    vecs[2]  = '{4'h8, 64'h3F8, 64'h0, 64'h40, 1'b1, 1'b0, 3'd1, 64'h1122334455667788, 9};
    vecs[3]  = '{4'h9, 64'h400, 64'h3F8, 64'h0, 1'b1, 1'b0, 3'd1, 64'h40, 9};
    vecs[4]  = '{4'hA, 64'h3F9, 64'hDEADBEEFDEADBEEF, 64'h0, 1'b1, 1'b0, 3'd3, 64'h40, 1};
    vecs[5]  = '{4'h5, 64'h3F8, 64'h0, 64'h0, 1'b1, 1'b0, 3'd1, 64'h40, 9};
    vecs[6]  = '{4'h5, 64'h13, 64'h0, 64'h0, 1'b0, 1'b1, 3'd3, 64'h40, 1};
    vecs[7]  = '{4'h4, 64'h13, 64'h0, 64'h0, 1'b0, 1'b0, 3'd4, 64'h40, 1};
    vecs[8]  = '{4'h0, 64'h13, 64'h0, 64'h0, 1'b1, 1'b0, 3'd2, 64'h40, 1};
    vecs[9]  = '{4'h6, 64'h13, 64'h0, 64'h0, 1'b1, 1'b0, 3'd1, 64'h40, 1};
    vecs[10] = '{4'hB, 64'h0, 64'h3F8, 64'h0, 1'b1, 1'b0, 3'd1, 64'h40, 9};
    vecs[11] = '{4'h5, 64'hFFFFFFFFFFFFFFF8, 64'h0, 64'h0, 1'b1, 1'b0, 3'd3, 64'h40, 1};
    vecs[12] = '{4'h5, 64'h13, 64'h0, 64'h0, 1'b1, 1'b0, 3'd1, 64'h1122334455667788, 9};

    rst_n = 1'b0;
    start = 1'b0;
    icode = 4'h0; valE = '0; valA = '0; valP = '0;
    instr_valid = 1'b1; imem_error = 1'b0;
    #12;
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_done", 64'(done), 64'd0);
    checkOutput("reset_valM", valM, 64'd0);
    checkOutput("reset_stat", 64'(stat), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) runVector(i);

    // Second start in cycle 4 of a write must be ignored.
    applyStimulus(4'h4, 64'h40, 64'hA5A55A5A01234567, 64'h0, 1'b1, 1'b0, 4);
    checkOutput("busyStart_doneCycle", 64'(doneCycle), 64'd9);
    checkOutput("busyStart_doneCount", 64'(doneCount), 64'd1);
    checkOutput("busyStart_stat", 64'(statAtDone), 64'd1);
    applyStimulus(4'h5, 64'h40, 64'h0, 64'h0, 1'b1, 1'b0, 0);
    checkOutput("busyStart_readback", valMAtDone, 64'hA5A55A5A01234567);

    // Reset during a write keeps the bytes already written.
    applyStimulus(4'h4, 64'h20, 64'hFFFFFFFFFFFFFFFF, 64'h0, 1'b1, 1'b0, 0);
    checkOutput("rstWr_fill_doneCycle", 64'(doneCycle), 64'd9);
    @(posedge clk);
    #1;
    icode = 4'h4; valE = 64'h20; valA = 64'h0;
    instr_valid = 1'b1; imem_error = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rstWr_busy", 64'(busy), 64'd0);
    checkOutput("rstWr_done", 64'(done), 64'd0);
    checkOutput("rstWr_valM", valM, 64'd0);
    checkOutput("rstWr_stat", 64'(stat), 64'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(4'h5, 64'h20, 64'h0, 64'h0, 1'b1, 1'b0, 0);
    checkOutput("rstWr_readCycle", 64'(doneCycle), 64'd9);
    checkOutput("rstWr_readback", valMAtDone, 64'hFFFFFFFFFF000000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
